// File: rtl/snn_pkg.sv
// Shared SNN definitions: FSM states, default sizes
// and the saturating membrane adder.
package snn_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FIRE  = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int PSUM_WIDTH    = 12;
    localparam int MEM_WIDTH     = 16;
    localparam int FILTER_SIZE   = 3;
    localparam int NUM_NEURONS   = 9;
    localparam int NUM_TIMESTEPS = 10;
    localparam int THRESHOLD     = 64;

    // Unsigned add clamped to all-ones on carry-out.
    function automatic logic [MEM_WIDTH-1:0] sat_add(
        input logic [MEM_WIDTH-1:0] a,
        input logic [MEM_WIDTH-1:0] b
    );
        logic [MEM_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[MEM_WIDTH] ? {MEM_WIDTH{1'b1}} : s[MEM_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/membrane_fire_logic.sv
// Combinational integrate-and-fire step.
// Ports: vmem_old, row_sum in; vmem_new, fire out.
module membrane_fire_logic
    import snn_pkg::*;
#(
    parameter int THRESH = THRESHOLD
) (
    input  logic [MEM_WIDTH-1:0] vmem_old,
    input  logic [MEM_WIDTH-1:0] row_sum,
    output logic [MEM_WIDTH-1:0] vmem_new,
    output logic                 fire
);

    localparam logic [MEM_WIDTH-1:0] TH = MEM_WIDTH'(THRESH);

    logic [MEM_WIDTH-1:0] sum;

    always_comb begin
        sum = sat_add(vmem_old, row_sum);
        fire = (sum >= TH);
        // Reset by subtraction keeps the overshoot as residual.
        vmem_new = fire ? (sum - TH) : sum;
    end

endmodule

// File: rtl/psum_membrane_unit.sv
// Row-psum accumulator, membrane integrator and spike emitter.
// Ports: psum valid/ready in, spike valid/ready out, ts_done/all_done.
module psum_membrane_unit
    import snn_pkg::*;
#(
    parameter int N_NEUR = NUM_NEURONS,
    parameter int N_TS   = NUM_TIMESTEPS,
    parameter int FSIZE  = FILTER_SIZE,
    parameter int THRESH = THRESHOLD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      psum_valid,
    output logic                      psum_ready,
    input  logic [PSUM_WIDTH-1:0]     psum_data,
    output logic                      spike_valid,
    input  logic                      spike_ready,
    output logic                      spike_data,
    output logic [$clog2(N_NEUR)-1:0] spike_addr,
    output logic                      spike_last,
    output logic                      ts_done,
    output logic                      all_done
);

    localparam int RW = (FSIZE > 1) ? $clog2(FSIZE) : 1;
    localparam int NW = $clog2(N_NEUR);
    localparam int TW = (N_TS > 1) ? $clog2(N_TS) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(FSIZE - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(N_NEUR - 1);
    localparam logic [TW-1:0] TS_LAST  = TW'(N_TS - 1);

    state_e state_q, state_d;

    logic [MEM_WIDTH-1:0] acc_q;
    logic [RW-1:0]        row_cnt_q;
    logic [NW-1:0]        neuron_cnt_q;
    logic [TW-1:0]        ts_cnt_q;
    logic [MEM_WIDTH-1:0] vmem_q [N_NEUR];

    logic spike_valid_q, spike_data_q, spike_last_q;
    logic [NW-1:0] spike_addr_q;
    logic ts_done_q, all_done_q;

    logic psum_xfer, spike_xfer, row_done;
    logic last_neuron, last_ts;
    logic [MEM_WIDTH-1:0] row_sum, vmem_new;
    logic fire;

    assign psum_xfer   = psum_valid & psum_ready;
    assign spike_xfer  = spike_valid_q & spike_ready;
    assign row_done    = psum_xfer & (row_cnt_q == ROW_LAST);
    assign last_neuron = (neuron_cnt_q == N_LAST);
    assign last_ts     = (ts_cnt_q == TS_LAST);
    assign row_sum     = acc_q + MEM_WIDTH'(psum_data);

    membrane_fire_logic #(
        .THRESH (THRESH)
    ) u_fire (
        .vmem_old (vmem_q[neuron_cnt_q]),
        .row_sum  (row_sum),
        .vmem_new (vmem_new),
        .fire     (fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (row_done) state_d = FIRE;
            FIRE: begin
                if (spike_xfer)
                    state_d = (last_neuron && last_ts) ? DONE : ACCUM;
            end
            DONE:    state_d = DONE;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        psum_ready = (state_q == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            row_cnt_q     <= '0;
            neuron_cnt_q  <= '0;
            ts_cnt_q      <= '0;
            spike_valid_q <= 1'b0;
            spike_data_q  <= 1'b0;
            spike_addr_q  <= '0;
            spike_last_q  <= 1'b0;
            ts_done_q     <= 1'b0;
            all_done_q    <= 1'b0;
            for (int i = 0; i < N_NEUR; i++) vmem_q[i] <= '0;
        end else begin
            ts_done_q <= 1'b0;
            if (row_done) begin
                vmem_q[neuron_cnt_q] <= vmem_new;
                spike_data_q  <= fire;
                spike_addr_q  <= neuron_cnt_q;
                spike_last_q  <= last_neuron;
                spike_valid_q <= 1'b1;
                acc_q         <= '0;
                row_cnt_q     <= '0;
            end else if (psum_xfer) begin
                acc_q     <= row_sum;
                row_cnt_q <= row_cnt_q + 1'b1;
            end
            if (state_q == FIRE && spike_xfer) begin
                spike_valid_q <= 1'b0;
                if (!last_neuron) begin
                    neuron_cnt_q <= neuron_cnt_q + 1'b1;
                end else begin
                    neuron_cnt_q <= '0;
                    ts_done_q    <= 1'b1;
                    if (last_ts) all_done_q <= 1'b1;
                    else         ts_cnt_q   <= ts_cnt_q + 1'b1;
                end
            end
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike_data  = spike_data_q;
    assign spike_addr  = spike_addr_q;
    assign spike_last  = spike_last_q;
    assign ts_done     = ts_done_q;
    assign all_done    = all_done_q;

endmodule

// File: tb/tb_psum_membrane_unit.sv
// Scoreboard bench for psum_membrane_unit.
// Reference membrane model predicts every spike result.
module tb_psum_membrane_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psum_valid = 1'b0;
    logic        psum_ready;
    logic [11:0] psum_data = '0;
    logic        spike_valid;
    logic        spike_ready = 1'b0;
    logic        spike_data;
    logic [3:0]  spike_addr;
    logic        spike_last;
    logic        ts_done;
    logic        all_done;

    always #5 clk = ~clk;

    psum_membrane_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .psum_data   (psum_data),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_data  (spike_data),
        .spike_addr  (spike_addr),
        .spike_last  (spike_last),
        .ts_done     (ts_done),
        .all_done    (all_done)
    );

    int total = 0;
    int bad   = 0;

    int m_vmem [9];
    int m_n;
    int m_ts;
    int exp_q [$];
    int tsd_cnt = 0;
    int last_wait;
    bit chk_ready_after;

    always @(posedge clk) if (ts_done === 1'b1) tsd_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        psum_valid  = 1'b0;
        spike_ready = 1'b0;
        rst_n       = 1'b0;
        #2;
        chk("rst_spike_valid", int'(spike_valid), 0);
        chk("rst_spike_data", int'(spike_data), 0);
        chk("rst_spike_addr", int'(spike_addr), 0);
        chk("rst_spike_last", int'(spike_last), 0);
        chk("rst_ts_done", int'(ts_done), 0);
        chk("rst_all_done", int'(all_done), 0);
        chk("rst_psum_ready", int'(psum_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 9; i++) m_vmem[i] = 0;
        m_n  = 0;
        m_ts = 0;
        exp_q.delete();
    endtask

    // Reference model: one neuron's row sum, then push the expected result.
    task automatic model_neuron(input int a, input int b, input int c);
        int nv;
        int f;
        nv = m_vmem[m_n] + a + b + c;
        if (nv > 65535) nv = 65535;
        f = (nv >= 64) ? 1 : 0;
        m_vmem[m_n] = f ? nv - 64 : nv;
        exp_q.push_back((f << 8) | (m_n << 1) | (m_n == 8 ? 1 : 0));
        if (m_n == 8) begin
            m_n = 0;
            m_ts++;
        end else begin
            m_n++;
        end
    endtask

    task automatic send_psum(input int v);
        int n = 0;
        psum_valid = 1'b1;
        psum_data  = 12'(v);
        while (psum_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("psum_timeout", 0, 1);
        @(posedge clk);
        #1 psum_valid = 1'b0;
    endtask

    task automatic get_spike(input int hold);
        int n = 0;
        int e;
        logic       d0;
        logic [3:0] a0;
        while (spike_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        last_wait = n;
        if (n >= 50) begin
            chk("spike_timeout", 0, 1);
            return;
        end
        d0 = spike_data;
        a0 = spike_addr;
        for (int i = 0; i < hold; i++) begin
            psum_valid = 1'b1;
            psum_data  = 12'd7;
            @(posedge clk);
            #1;
            chk("bp_valid", int'(spike_valid), 1);
            chk("bp_data", int'(spike_data), int'(d0));
            chk("bp_addr", int'(spike_addr), int'(a0));
            chk("bp_psum_ready", int'(psum_ready), 0);
        end
        psum_valid = 1'b0;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("spike_data", int'(spike_data), (e >> 8) & 1);
            chk("spike_addr", int'(spike_addr), (e >> 1) & 15);
            chk("spike_last", int'(spike_last), e & 1);
        end
        spike_ready = 1'b1;
        @(posedge clk);
        #1 spike_ready = 1'b0;
        if (chk_ready_after) chk("ready_after", int'(psum_ready), 1);
    endtask

    task automatic neuron(input int a, input int b, input int c);
        model_neuron(a, b, c);
        send_psum(a);
        send_psum(b);
        send_psum(c);
        get_spike(0);
    endtask

    initial begin
        int base;
        int r0, r1, r2;
        chk_ready_after = 1'b0;

        // Reset mid-stream after two of three psums.
        do_reset();
        send_psum(9);
        send_psum(9);
        do_reset();
        neuron(5, 5, 5);
        chk("t1_vmem0", int'(dut.vmem_q[0]), 15);

        // Integrate across timesteps, fire at equality.
        do_reset();
        neuron(10, 20, 30);
        chk("t2_latency", last_wait, 0);
        chk("t2_vmem0", int'(dut.vmem_q[0]), 60);
        for (int i = 1; i < 9; i++) neuron(0, 0, 0);
        neuron(1, 2, 1);
        chk("t2_vmem0_eq", int'(dut.vmem_q[0]), 0);

        // Residual after firing.
        do_reset();
        for (int i = 0; i < 4; i++) neuron(0, 0, 0);
        neuron(100, 0, 0);
        chk("t3_vmem4", int'(dut.vmem_q[4]), 36);

        // Backpressure with a psum offered while in FIRE.
        model_neuron(3, 4, 5);
        send_psum(3);
        send_psum(4);
        send_psum(5);
        chk_ready_after = 1'b1;
        get_spike(5);
        chk_ready_after = 1'b0;
        neuron(1, 1, 1);
        chk("t4_vmem6", int'(dut.vmem_q[6]), 3);

        // Full run with random psums.
        do_reset();
        base = tsd_cnt;
        for (int k = 0; k < 90; k++) begin
            r0 = $urandom_range(20, 0);
            r1 = $urandom_range(20, 0);
            r2 = $urandom_range(20, 0);
            neuron(r0, r1, r2);
            if (k == 88) chk("t5_not_done", int'(all_done), 0);
        end
        chk("t5_all_done", int'(all_done), 1);
        @(posedge clk);
        #1;
        chk("t5_ts_done_cnt", tsd_cnt - base, 10);
        psum_valid = 1'b1;
        psum_data  = 12'd1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t5_ready_low", int'(psum_ready), 0);
            chk("t5_all_done_hold", int'(all_done), 1);
        end
        psum_valid = 1'b0;
        chk("t5_sb_empty", exp_q.size(), 0);

        // Saturation on neuron 0.
        do_reset();
        for (int t = 0; t < 7; t++) begin
            neuron(4095, 4095, 4095);
            for (int i = 1; i < 9; i++) neuron(0, 0, 0);
            if (t == 4) chk("t6_vmem_61105", int'(dut.vmem_q[0]), 61105);
        end
        chk("t6_vmem_sat", int'(dut.vmem_q[0]), 65471);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_membrane_unit.md
Name: psum_membrane_unit

Overview:
- Downstream stage of the PE array. Consumes the partial-sum stream emitted by the PEs' psum output.
- Sums FILTER_SIZE row psums into one output-neuron contribution and integrates it into a per-neuron membrane potential.
- Fires a spike when the membrane reaches THRESHOLD, using reset-by-subtraction.
- Spikes go out on a valid/ready channel toward the output spike buffer / NoC packetizer.

Parameters:
- PSUM_WIDTH, 12, width of incoming psum (unsigned, same as PE WIDTH).
- MEM_WIDTH, 16, membrane potential and row-accumulator width.
- FILTER_SIZE, 3, psums per output neuron (one per PE row).
- NUM_NEURONS, 9, output neurons per timestep (3x3 output map).
- NUM_TIMESTEPS, 10, timesteps per inference run.
- THRESHOLD, 64, firing threshold (unsigned, < 2^MEM_WIDTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- psum_valid  in  1  psum offered.
- psum_ready  out  1  unit accepts a psum.
- psum_data  in  PSUM_WIDTH  partial sum value.
- spike_valid  out  1  spike result offered.
- spike_ready  in  1  consumer accepts the result.
- spike_data  out  1  1 = neuron fired this timestep.
- spike_addr  out  clog2(NUM_NEURONS)  neuron index of the result.
- spike_last  out  1  result is for neuron NUM_NEURONS-1.
- ts_done  out  1  one-cycle pulse when a timestep completes.
- all_done  out  1  level; run complete.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state=ACCUM; acc, row_cnt, neuron_cnt, ts_cnt, every vmem[i] cleared; spike_valid=0, spike_data=0, spike_addr=0, spike_last=0, ts_done=0, all_done=0.
  - psum_ready is state-decoded, so it reads 1 during and after reset.
  - Reset mid-operation discards any in-flight psums and pending spike with no partial output.
- Handshakes:
  - A transfer occurs on a rising edge with valid&ready both high.
  - The producer must hold its data stable while valid is high and not ready.
  - spike_valid/data/addr/last are registered and stable until accepted.
- FSM ACCUM:
  - psum_ready=1. On each psum transfer: acc += psum_data (zero-extended); row_cnt++.
  - On the transfer with row_cnt==FILTER_SIZE-1, the same edge:
    - new = vmem[n] + acc + psum_data, saturated at 2^MEM_WIDTH-1, where n = neuron_cnt.
    - If new >= THRESHOLD: spike_data<=1, vmem[n]<=new-THRESHOLD. Else spike_data<=0, vmem[n]<=new.
    - spike_addr<=n; spike_last<=(n==NUM_NEURONS-1); spike_valid<=1; acc<=0; row_cnt<=0; go FIRE.
  - Latency: the last psum accepted at edge t gives spike_valid high after edge t.
- FSM FIRE:
  - psum_ready=0. Wait for spike_ready.
  - On acceptance: spike_valid<=0.
  - If n<NUM_NEURONS-1: neuron_cnt++, go ACCUM.
  - Else (timestep wrap): neuron_cnt<=0, ts_done<=1 for one cycle.
    - If ts_cnt==NUM_TIMESTEPS-1: go DONE, all_done<=1.
    - Else: ts_cnt++, go ACCUM.
- FSM DONE:
  - psum_ready=0, all_done=1; psums are ignored. Only reset leaves DONE.
- Membrane persistence: vmem persists across timesteps and is cleared only by reset.
- Width rules:
  - acc never overflows (FILTER_SIZE*(2^PSUM_WIDTH-1) < 2^MEM_WIDTH).
  - vmem add saturates; after saturation the threshold subtraction still applies.
- Boundary conditions:
  - Zero psums are valid data and count toward row_cnt.
  - new==THRESHOLD fires with residual 0.
  - spike_ready held high in FIRE gives one result per FILTER_SIZE+1 cycles at best.

Decomposition:
- Shared package snn_pkg:
  - State enum {ACCUM, FIRE, DONE}.
  - Default width and size constants: PSUM_WIDTH, MEM_WIDTH, FILTER_SIZE, NUM_NEURONS, NUM_TIMESTEPS, THRESHOLD.
  - A saturating-add function.
- One combinational sub-module, membrane_fire_logic: inputs vmem_old, row_sum; outputs vmem_new, fire. Contains saturate, compare and subtract.
- The FSM, counters and the vmem register array stay in the top.

Test Plan:
1. Reset check: assert rst_n=0 mid-stream after 2 of 3 psums, then release. All outputs read 0 and psum_ready=1; the next 3 psums (5,5,5) give addr 0, vmem 15, spike_data 0.
2. Integrate over timesteps:
   - Timestep 0, neuron 0 psums 10,20,30 gives spike_data 0, vmem[0]=60.
   - Timestep 1, neuron 0 psums 1,2,1 gives spike_data 1, vmem[0]=0 (fires at equality).
3. Residual: neuron 4 psums 100,0,0 gives spike_data 1, spike_addr 4, vmem[4]=36.
4. Backpressure: hold spike_ready=0 for 5 cycles after spike_valid. spike_valid, data and addr stay stable, psum_ready=0, and the offered psum is not consumed. Raising spike_ready completes the transfer and psum_ready returns to 1 the next cycle.
5. Full run: 10 timesteps x 9 neurons with random psums 0..20.
   - 90 spike transfers; spike_last on every addr 8; exactly 10 ts_done pulses.
   - all_done=1 after the 90th acceptance, and psum_ready then stays 0.
   - Spike pattern matches the reference model.
6. Saturation: neuron 0 gets psums 4095,4095,4095 for 6 timesteps (others 0).
   - vmem[0] after timestep 5 is 61105.
   - Timestep 6 sums to 73390, saturates to 65535, spikes, and leaves vmem[0]=65471.
